// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner state, default
// starvation limit and the bundled memory request payload.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_CORE = 1'b0,
    ST_DBG  = 1'b1
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store unit and a debug/loader
// port. The core normally wins; debug wins when the core is idle or when it
// has watched STARVE_LIMIT consecutive core grants go by.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_cs,
  input  logic        core_wr,
  input  logic [3:0]  core_mask,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [3:0]  dbg_mask,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       core_gnt;
  mem_req_t   core_r, dbg_r, gnt_r;

  // Debug wins when the core is idle or has used up its starvation budget.
  // The ST_DBG term only restates the idle-core case; it is kept so the
  // owner state is an explicit input of the decision.
  function automatic logic dbg_wins(input logic   req,
                                    input logic   cs,
                                    input logic [3:0] cnt,
                                    input owner_e st);
    return req && (!cs || (cnt == LIMIT) || (st == ST_DBG && !cs));
  endfunction

  assign core_r = '{wr: core_wr, mask: core_mask, addr: core_addr, wdata: core_wdata};
  assign dbg_r  = '{wr: dbg_wr,  mask: dbg_mask,  addr: dbg_addr,  wdata: dbg_wdata};

  assign dbg_gnt    = dbg_wins(dbg_req, core_cs, starve_cnt, state);
  assign core_gnt   = core_cs && !dbg_gnt;
  assign core_stall = core_cs && dbg_gnt;
  assign core_rdata = core_gnt ? mem_rdata : '0;

  // Memory port mux; everything drops to zero when nobody is granted.
  always_comb begin
    gnt_r = '0;
    if (dbg_gnt)       gnt_r = dbg_r;
    else if (core_gnt) gnt_r = core_r;
  end

  assign mem_cs    = dbg_gnt || core_gnt;
  assign mem_wr    = gnt_r.wr;
  assign mem_mask  = gnt_r.mask;
  assign mem_addr  = gnt_r.addr;
  assign mem_wdata = gnt_r.wdata;

  // Owner state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_CORE;
    else      state <= state_nxt;
  end

  // Owner follows the last grant; no grant keeps the previous owner.
  always_comb begin
    state_nxt = state;
    if (dbg_gnt)       state_nxt = ST_DBG;
    else if (core_gnt) state_nxt = ST_CORE;
  end

  // Count core grants that happened while debug was waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 starve_cnt <= '0;
    else if (dbg_gnt || !dbg_req)             starve_cnt <= '0;
    else if (core_gnt && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
  end

  // Registered debug read response: one-cycle valid, data held until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_gnt && !dbg_wr;
      if (dbg_gnt && !dbg_wr) dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a behavioural model
// (waiting-count arbitration rule plus a reference word memory).
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_cs, core_wr, dbg_req, dbg_wr;
  logic [3:0]  core_mask, dbg_mask;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_stall, dbg_gnt, dbg_rvalid, mem_cs, mem_wr;
  logic [3:0]  mem_mask;

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  int          m_wait;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        o_gnt, o_stall, o_memwr;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .core_cs(core_cs), .core_wr(core_wr), .core_mask(core_mask),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_mask(dbg_mask),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory driven by the DUT's memory port.
  assign mem_rdata = env_mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_cs && mem_wr)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set after a negedge. Checks combinational
  // outputs, optionally drops reset before the edge, then checks registers.
  task automatic tick(input bit mid_rst = 1'b0);
    logic dg, cg, ewr;
    logic [3:0] em;
    logic [31:0] ea, ew, rd;
    #1;
    dg = dbg_req && (!core_cs || m_wait >= LIM);
    cg = core_cs && !dg;
    ewr = dg ? dbg_wr : (cg ? core_wr : 1'b0);
    em  = dg ? dbg_mask : (cg ? core_mask : 4'h0);
    ea  = dg ? dbg_addr : (cg ? core_addr : 32'h0);
    ew  = dg ? dbg_wdata : (cg ? core_wdata : 32'h0);
    rd  = ref_mem[ea[9:2]];
    chk("dbg_gnt", dbg_gnt, dg);
    chk("core_stall", core_stall, core_cs && dg);
    chk("mem_cs", mem_cs, dg || cg);
    chk("mem_wr", mem_wr, ewr);
    chk("mem_mask", mem_mask, em);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("core_rdata", core_rdata, cg ? rd : 32'h0);
    o_gnt = dbg_gnt; o_stall = core_stall; o_memwr = mem_wr;
    if (mid_rst) rst = 1'b0;
    @(posedge clk);
    if ((dg || cg) && ewr)
      for (int b = 0; b < 4; b++)
        if (em[b]) ref_mem[ea[9:2]][8*b +: 8] = ew[8*b +: 8];
    if (!rst) begin
      m_wait = 0; m_rvalid = 1'b0; m_rdata = 32'h0;
    end else begin
      m_rvalid = dg && !dbg_wr;
      if (m_rvalid) m_rdata = rd;
      if (dg || !dbg_req) m_wait = 0;
      else if (cg && m_wait < LIM) m_wait++;
    end
    #1;
    chk("dbg_rvalid", dbg_rvalid, m_rvalid);
    chk("dbg_rdata", dbg_rdata, m_rdata);
    @(negedge clk);
  endtask

  task automatic idle();
    core_cs = 0; core_wr = 0; core_mask = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_wr = 0; dbg_mask = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  initial begin
    logic prev_stall, prev_dgnt;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom; ref_mem[i] = env_mem[i];
    end
    env_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    m_wait = 0; m_rvalid = 0; m_rdata = 0;
    idle();
    rst = 1'b0;
    @(negedge clk);

    // Reset state, then a debug read granted during reset gives no response.
    tick();
    chk("rst_mem_cs", mem_cs, 32'h0);
    dbg_req = 1; dbg_addr = 32'h10;
    tick();
    chk("rst_read_gnt", o_gnt, 1);
    chk("rst_read_rvalid", dbg_rvalid, 0);
    idle();
    rst = 1'b1;
    tick();

    // Debug-only read of 0x10.
    dbg_req = 1; dbg_addr = 32'h10;
    tick();
    chk("dread_gnt", o_gnt, 1);
    chk("dread_stall", o_stall, 0);
    chk("dread_rvalid", dbg_rvalid, 1);
    chk("dread_rdata", dbg_rdata, 32'hDEADBEEF);
    idle();
    tick();
    chk("dread_pulse", dbg_rvalid, 0);

    // Core store, then debug read back.
    core_cs = 1; core_wr = 1; core_mask = 4'hF; core_addr = 32'h20; core_wdata = 32'h12345678;
    #1;
    chk("csw_mem_cs", mem_cs, 1);
    chk("csw_mem_wr", mem_wr, 1);
    chk("csw_mem_addr", mem_addr, 32'h20);
    chk("csw_mem_wdata", mem_wdata, 32'h12345678);
    chk("csw_mem_mask", mem_mask, 4'hF);
    tick();
    idle();
    dbg_req = 1; dbg_addr = 32'h20;
    tick();
    chk("csw_readback", dbg_rdata, 32'h12345678);

    // Debug write with core idle.
    idle();
    dbg_req = 1; dbg_wr = 1; dbg_mask = 4'h3; dbg_addr = 32'h40; dbg_wdata = 32'hCAFEF00D;
    tick();
    chk("dwr_gnt", o_gnt, 1);
    chk("dwr_memwr", o_memwr, 1);
    chk("dwr_rvalid", dbg_rvalid, 0);
    idle();
    tick();
    chk("dwr_memwr_after", o_memwr, 0);

    // Sustained conflict: debug gets cycles 4 and 9.
    core_cs = 1; core_addr = 32'h80;
    dbg_req = 1; dbg_addr = 32'h84;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("conflict_gnt%0d", i), o_gnt, (i == 4 || i == 9));
      chk($sformatf("conflict_stall%0d", i), o_stall, (i == 4 || i == 9));
    end
    idle();
    tick();

    // Reset asserted right after a debug read grant drops the response.
    dbg_req = 1; dbg_addr = 32'h10;
    tick(1'b1);
    chk("midrst_rvalid", dbg_rvalid, 0);
    chk("midrst_rdata", dbg_rdata, 32'h0);
    idle();
    tick();
    rst = 1'b1;
    core_cs = 1; core_addr = 32'h8;
    dbg_req = 1; dbg_addr = 32'hC;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_gnt%0d", i), o_gnt, (i == 4));
    end
    idle();
    tick();

    // Random traffic; stalled core access and waiting debug request are held.
    prev_stall = 0; prev_dgnt = 1;
    for (int n = 0; n < 400; n++) begin
      if (!prev_stall) begin
        core_cs = ($urandom_range(0, 9) < 6);
        core_wr = $urandom_range(0, 1);
        core_mask = 4'($urandom);
        core_addr = {22'h0, 8'($urandom), 2'b00};
        core_wdata = $urandom;
      end
      if (!dbg_req || prev_dgnt) begin
        dbg_req = ($urandom_range(0, 9) < 4);
        dbg_wr = $urandom_range(0, 1);
        dbg_mask = 4'($urandom);
        dbg_addr = {22'h0, 8'($urandom), 2'b00};
        dbg_wdata = $urandom;
      end
      if (prev_stall) begin
        #1;
        chk("stall_regrant", core_stall, 0);
      end
      tick();
      prev_stall = o_stall;
      prev_dgnt = o_gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive core grants while debug waits (range 1..15).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 core_cs/core_wr  in  1/1  memory-stage access request and write enable from the load/store unit.
REQ-005 core_mask/core_addr/core_wdata  in  4/32/32  core byte mask, address and write data.
REQ-006 core_rdata  out  32  memory read data returned to the load/store unit.
REQ-007 core_stall  out  1  core access not served this cycle; drives the hazard unit to hold F/D/E/M and bubble W.
REQ-008 dbg_req/dbg_wr  in  1/1  debug/loader request and write enable; held with payload until granted.
REQ-009 dbg_mask/dbg_addr/dbg_wdata  in  4/32/32  debug byte mask, address and write data.
REQ-010 dbg_gnt  out  1  debug access performed this cycle.
REQ-011 dbg_rvalid/dbg_rdata  out  1/32  registered debug read response.
REQ-012 mem_cs/mem_wr/mem_mask/mem_addr/mem_wdata  out  1/1/4/32/32  to the data memory.
REQ-013 mem_rdata  in  32  combinational read data from the data memory.

Function
REQ-014 State: owner FSM {ST_CORE, ST_DBG}, starve_cnt[3:0], rvalid/rdata registers.
REQ-015 Grant to debug in a cycle iff dbg_req and (!core_cs or starve_cnt == STARVE_LIMIT or state == ST_DBG with core_cs == 0).
REQ-016 Otherwise grant to core iff core_cs; no grant means mem_cs = 0.
REQ-017 Memory outputs SHALL be a combinational mux of the granted requester's signals; mem_wr, mem_mask and mem_wdata are 0 when there is no grant.
REQ-018 core_stall = core_cs and debug granted, combinationally, in the same cycle.
REQ-019 core_rdata = mem_rdata whenever the core is granted, else 0.
REQ-020 dbg_gnt = debug granted, combinational, one cycle per access.
REQ-021 On a debug read grant, dbg_rdata <= mem_rdata and dbg_rvalid <= 1 at the next edge; dbg_rvalid is a 1-cycle pulse; dbg_rdata holds until the next debug read.
REQ-022 A debug write grant SHALL NOT assert dbg_rvalid.
REQ-023 starve_cnt increments (saturating at STARVE_LIMIT) when dbg_req is high and the core is granted; clears on any debug grant or when dbg_req is low.
REQ-024 State transitions to ST_DBG on a debug grant, and to ST_CORE on a core grant; it holds when there is no grant.
REQ-025 Back-to-back debug requests with core idle are granted every cycle.
REQ-026 With core_cs continuously high and dbg_req continuously high, the grant pattern SHALL be STARVE_LIMIT core, then 1 debug, repeating.
REQ-027 A stalled core access is re-presented unchanged and SHALL be granted the following cycle, because the counter was cleared.
REQ-028 Both requesters idle: all mem_* are 0, state and counter hold except for the REQ-023 clear.

Reset
REQ-029 While rst = 0: state = ST_CORE, starve_cnt = 0, dbg_rvalid = 0, dbg_rdata = 0.
REQ-030 Combinational outputs follow REQ-015..020 during reset with starve_cnt = 0; a read granted in the reset cycle produces no dbg_rvalid.
REQ-031 Reset assertion mid-transaction drops any pending dbg_rvalid; the requester re-issues the access.

Structure
REQ-032 Owner-state enum and the default STARVE_LIMIT constant SHALL live in the shared core package.
REQ-033 Single module with no sub-modules; a grant-decision function is permitted inside it.

Verification
REQ-034 Debug-only read: dbg_req=1, dbg_wr=0, dbg_addr=0x10, memory word 0xDEADBEEF -> dbg_gnt=1 in cycle 0; dbg_rvalid=1 and dbg_rdata=0xDEADBEEF in cycle 1; core_stall=0.
REQ-035 Conflict with STARVE_LIMIT=4: core_cs and dbg_req held high for 12 cycles -> debug grants in cycles 4 and 9, with core_stall high only in those cycles.
REQ-036 Core sw of 0x12345678 to 0x20 with mask 0xF, while debug is idle -> mem_* mirror core inputs in the same cycle; a subsequent debug read of 0x20 returns 0x12345678.
REQ-037 Debug write with core_cs=0 -> dbg_gnt=1, no dbg_rvalid, and mem_wr=1 only in that cycle.
REQ-038 rst driven low the cycle after a debug read grant -> dbg_rvalid stays 0, dbg_rdata=0, and starve_cnt=0 after release.
